ifmap_spad_fill_ctrl: RTL and testbench

- Write-side controller sitting directly upstream of register_type_scratchpad.
- Accepts a valid/ready input stream and writes each word into the scratchpad as a circular buffer of DEPTH entries.
- Tracks occupancy and exposes the oldest-entry pointer and a window-available flag to the downstream window reader.
- The reader frees consumed entries by issuing release requests (stride-sized).

---
 rtl/ifmap_spad_fill_ctrl_if.sv | 37 +++
 rtl/ifmap_spad_fill_ctrl.sv | 79 +++++++
 tb/tb_ifmap_spad_fill_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ifmap_spad_fill_ctrl_if.sv
// Handshake and status bundle between the input stream, the ifmap scratchpad
// fill controller, the scratchpad write port and the downstream window reader.
interface ifmap_spad_fill_ctrl_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 4
);
    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  spad_wen;
    logic [ADDR_WIDTH-1:0] spad_waddr;
    logic [DATA_WIDTH-1:0] spad_din;
    logic                  release_valid;
    logic [CNT_WIDTH-1:0]  release_cnt;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  win_ready;
    logic                  rel_err;

    // Stream source / reader / control side
    modport master (
        output flush, in_valid, in_data, release_valid, release_cnt,
        input  in_ready, spad_wen, spad_waddr, spad_din, rd_base, count,
               full, empty, win_ready, rel_err
    );

    // Controller side
    modport slave (
        input  flush, in_valid, in_data, release_valid, release_cnt,
        output in_ready, spad_wen, spad_waddr, spad_din, rd_base, count,
               full, empty, win_ready, rel_err
    );
endinterface

// File: rtl/ifmap_spad_fill_ctrl.sv
// Write-side controller for the ifmap register scratchpad: treats the
// scratchpad as a circular buffer of DEPTH entries, writes accepted stream
// words at wptr, and frees the oldest entries on reader release requests.
module ifmap_spad_fill_ctrl #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 10,
    parameter int WIN_SIZE   = 3,
    parameter int CNT_WIDTH  = 4
) (
    input logic                     clk,
    input logic                     rst,
    ifmap_spad_fill_ctrl_if.slave   bus
);
    // One extra bit so rptr + release_cnt never overflows before the wrap
    localparam int SUM_W = ((ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH) + 1;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  rel_err_q;

    logic                  full_c;
    logic                  wr;
    logic                  rel_ok;
    logic [CNT_WIDTH-1:0]  rel_amt;
    logic [SUM_W-1:0]      rsum;
    logic [ADDR_WIDTH-1:0] rptr_nxt;
    logic [ADDR_WIDTH-1:0] wptr_nxt;

    assign full_c = (count_q == CNT_WIDTH'(DEPTH));

    // Handshake, release legality and next-pointer arithmetic
    always_comb begin
        wr      = bus.in_valid & ~full_c & ~bus.flush & ~rst;
        rel_ok  = bus.release_valid & (bus.release_cnt <= count_q);
        rel_amt = rel_ok ? bus.release_cnt : '0;
        rsum    = SUM_W'(rptr) + SUM_W'(rel_amt);
        if (rsum >= SUM_W'(DEPTH)) begin
            rsum = rsum - SUM_W'(DEPTH);
        end
        rptr_nxt = ADDR_WIDTH'(rsum);
        wptr_nxt = (wptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wptr + 1'b1;
    end

    // Pointer, occupancy and release-error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            rel_err_q <= 1'b0;
        end else if (bus.flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            rel_err_q <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr_nxt;
            end
            rptr      <= rptr_nxt;
            count_q   <= count_q + CNT_WIDTH'(wr) - rel_amt;
            rel_err_q <= bus.release_valid & ~rel_ok;
        end
    end

    assign bus.in_ready   = ~full_c;
    assign bus.spad_wen   = wr;
    assign bus.spad_waddr = wptr;
    assign bus.spad_din   = bus.in_data;
    assign bus.rd_base    = rptr;
    assign bus.count      = count_q;
    assign bus.full       = full_c;
    assign bus.empty      = (count_q == '0);
    assign bus.win_ready  = (count_q >= CNT_WIDTH'(WIN_SIZE));
    assign bus.rel_err    = rel_err_q;

endmodule

// File: tb/tb_ifmap_spad_fill_ctrl.sv
// Directed self-checking bench for ifmap_spad_fill_ctrl (DEPTH=10, WIN_SIZE=3).
module tb_ifmap_spad_fill_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;

    ifmap_spad_fill_ctrl_if #(.DATA_WIDTH(3), .ADDR_WIDTH(4), .CNT_WIDTH(4)) bus ();

    ifmap_spad_fill_ctrl #(
        .DATA_WIDTH(3), .ADDR_WIDTH(4), .DEPTH(10), .WIN_SIZE(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, check the scratchpad write port, then take the edge
    task automatic write_word(input logic [2:0] d, input logic [3:0] a);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        check("wen", bus.spad_wen, 1);
        check("waddr", bus.spad_waddr, a);
        check("din", bus.spad_din, d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic release_n(input logic [3:0] n);
        bus.release_valid = 1'b1;
        bus.release_cnt   = n;
        tick();
        bus.release_valid = 1'b0;
        bus.release_cnt   = '0;
    endtask

    task automatic check_state(input string tag, input int cnt, input int base);
        check({tag, "_count"}, bus.count, cnt);
        check({tag, "_rd_base"}, bus.rd_base, base);
        check({tag, "_full"}, bus.full, (cnt == 10) ? 1 : 0);
        check({tag, "_empty"}, bus.empty, (cnt == 0) ? 1 : 0);
        check({tag, "_in_ready"}, bus.in_ready, (cnt == 10) ? 0 : 1);
        check({tag, "_win_ready"}, bus.win_ready, (cnt >= 3) ? 1 : 0);
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 3'd7;
        bus.release_valid = 1'b0;
        bus.release_cnt = '0;

        // Reset values, including wen held low despite in_valid
        #2;
        check_state("rst", 0, 0);
        check("rst_wen", bus.spad_wen, 0);
        check("rst_rel_err", bus.rel_err, 0);
        bus.in_valid = 1'b0;
        #1 rst = 1'b0;
        tick();
        check_state("idle", 0, 0);

        // Stream 3,4,5
        write_word(3'd3, 4'd0);
        write_word(3'd4, 4'd1);
        check("win_ready_at_2", bus.win_ready, 0);
        write_word(3'd5, 4'd2);
        check_state("three", 3, 0);

        // Fill to DEPTH
        for (int i = 3; i < 10; i++) begin
            write_word(3'(i), 4'(i));
        end
        check_state("full", 10, 0);

        // 11th word refused
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd1;
        #1;
        check("full_wen", bus.spad_wen, 0);
        tick();
        bus.in_valid = 1'b0;
        check_state("full_hold", 10, 0);

        // Release 3 from full, then refill across the wrap
        release_n(4'd3);
        check_state("rel3", 7, 3);
        write_word(3'd1, 4'd0);
        write_word(3'd2, 4'd1);
        write_word(3'd3, 4'd2);
        check_state("refull", 10, 3);

        // Move rptr to 8, then release 4 wrapping to 2
        release_n(4'd5);
        check_state("rel5", 5, 8);
        release_n(4'd4);
        check_state("rel4_wrap", 1, 2);

        // Back to count=5, then simultaneous write and release 2
        for (int i = 0; i < 4; i++) begin
            write_word(3'(i), 4'(3 + i));
        end
        check_state("cnt5", 5, 2);
        bus.release_valid = 1'b1;
        bus.release_cnt   = 4'd2;
        write_word(3'd6, 4'd7);
        bus.release_valid = 1'b0;
        check_state("wr_rel", 4, 4);
        check("wr_rel_err", bus.rel_err, 0);

        // Down to count=2, illegal release 3 with same-cycle write
        release_n(4'd2);
        check_state("cnt2", 2, 6);
        bus.release_valid = 1'b1;
        bus.release_cnt   = 4'd3;
        write_word(3'd2, 4'd8);
        bus.release_valid = 1'b0;
        check_state("bad_rel", 3, 6);
        check("bad_rel_err", bus.rel_err, 1);
        release_n(4'd0);
        check("rel_err_cleared", bus.rel_err, 0);
        check_state("rel0", 3, 6);

        // Flush with write and release both requested
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.release_valid = 1'b1;
        bus.release_cnt = 4'd1;
        #1;
        check("flush_wen", bus.spad_wen, 0);
        check("flush_in_ready", bus.in_ready, 1);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.release_valid = 1'b0;
        check_state("flushed", 0, 0);
        check("flush_rel_err", bus.rel_err, 0);

        // Pointers restart at 0; release equal to count is legal
        write_word(3'd4, 4'd0);
        write_word(3'd5, 4'd1);
        release_n(4'd2);
        check_state("rel_eq", 0, 2);
        check("rel_eq_err", bus.rel_err, 0);
        write_word(3'd1, 4'd2);
        write_word(3'd2, 4'd3);
        write_word(3'd3, 4'd4);
        check_state("pre_rst", 3, 2);

        // Async reset mid-write, checked before any clock edge
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd6;
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 0, 0);
        check("async_rst_wen", bus.spad_wen, 0);
        check("async_rst_rel_err", bus.rel_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
